hwf_operand_streamer: RTL and testbench

//  Transmit side of the pixel-operand interface into the HWF kernel. Reads the

---
 rtl/hwf_pkg.sv | 25 ++
 rtl/hwf_skid_fifo.sv | 46 ++++
 rtl/hwf_operand_streamer.sv | 164 ++++++++++++++++
 tb/tb_hwf_operand_streamer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hwf_pkg.sv
// Shared constants, derived widths and FSM encoding for the HWF operand path.
package hwf_pkg;

   localparam int          XLEN_PIXEL    = 8;
   localparam int          NUM_OF_PIXELS = 4;
   localparam int          NUM_OF_SV     = 87;
   localparam logic [15:0] BI_ONE        = 16'h0100;

   // $clog2 floored at 1 so single-entry dimensions still get a 1-bit field
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int PIX_AW = clog2_min1(NUM_OF_PIXELS);
   localparam int SV_IW  = clog2_min1(NUM_OF_SV);
   localparam int SV_AW  = clog2_min1(NUM_OF_SV * NUM_OF_PIXELS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/hwf_skid_fifo.sv
// Two-entry FIFO holding ROM data plus issue-time tags; head is always mem[rd_ptr].
module hwf_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem_r [2];
   logic         wr_ptr_r;
   logic         rd_ptr_r;
   logic [1:0]   count_r;

   // Storage, pointers and occupancy; the caller never pushes when full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r[0] <= {W{1'b0}};
         mem_r[1] <= {W{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/hwf_operand_streamer.sv
// Streams (x_test, x_sv) pixel pairs SV-major from the test/SV ROMs into hwf_kernel.
module hwf_operand_streamer #(
   parameter int                      XLEN_PIXEL    = hwf_pkg::XLEN_PIXEL,
   parameter int                      NUM_OF_PIXELS = hwf_pkg::NUM_OF_PIXELS,
   parameter int                      NUM_OF_SV     = hwf_pkg::NUM_OF_SV,
   parameter logic [2*XLEN_PIXEL-1:0] BI_INIT       = hwf_pkg::BI_ONE,
   localparam int PIX_W  = hwf_pkg::clog2_min1(NUM_OF_PIXELS),
   localparam int SV_W   = hwf_pkg::clog2_min1(NUM_OF_SV),
   localparam int ADDR_W = hwf_pkg::clog2_min1(NUM_OF_SV * NUM_OF_PIXELS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    kernel_rdy,
   output logic [PIX_W-1:0]        test_addr,
   input  logic [XLEN_PIXEL-1:0]   test_rdata,
   output logic [ADDR_W-1:0]       sv_addr,
   input  logic [XLEN_PIXEL-1:0]   sv_rdata,
   output logic                    rd_en,
   output logic [XLEN_PIXEL-1:0]   x_test,
   output logic [XLEN_PIXEL-1:0]   x_sv,
   output logic [2*XLEN_PIXEL-1:0] Bi,
   output logic [SV_W-1:0]         sv_idx,
   output logic                    px_first,
   output logic                    px_last,
   output logic                    stall_MEM,
   output logic                    busy,
   output logic                    done
);

   import hwf_pkg::*;

   localparam int               ENT_W    = 2*XLEN_PIXEL + SV_W + 2;
   localparam int               XS_LO    = SV_W + 2;
   localparam int               XT_LO    = XS_LO + XLEN_PIXEL;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_OF_PIXELS - 1);
   localparam logic [SV_W-1:0]  SV_LAST  = SV_W'(NUM_OF_SV - 1);

   state_t              state_r;
   logic [PIX_W-1:0]    pix_cnt_r;
   logic [SV_W-1:0]     sv_cnt_r;
   logic [ADDR_W-1:0]   lin_cnt_r;
   logic                inflight_r;
   logic [SV_W+1:0]     tag_r;
   logic                busy_r;
   logic                done_r;

   logic [1:0]          count_s;
   logic [ENT_W-1:0]    fifo_head_s;
   logic [ENT_W-1:0]    incoming_s;
   logic [ENT_W-1:0]    head_s;
   logic                head_valid_s;
   logic                xfer_s;
   logic                push_s;
   logic                pop_s;
   logic                rd_en_s;
   logic                last_rd_s;
   logic [2:0]          occupancy_s;

   // ROM data lands one cycle after issue; it pairs with the tags registered at issue
   assign incoming_s = {test_rdata, sv_rdata, tag_r};

   hwf_skid_fifo #(.W(ENT_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (incoming_s),
      .head  (fifo_head_s),
      .count (count_s)
   );

   // Head selection with FIFO bypass, transfer handshake and read throttling
   always_comb begin
      occupancy_s  = {1'b0, count_s} + {2'b00, inflight_r};
      head_valid_s = (count_s != 2'd0) || inflight_r;
      xfer_s       = head_valid_s && kernel_rdy;
      pop_s        = xfer_s && (count_s != 2'd0);
      push_s       = inflight_r && !(xfer_s && (count_s == 2'd0));
      if (count_s != 2'd0) begin
         head_s = fifo_head_s;
      end else if (inflight_r) begin
         head_s = incoming_s;
      end else begin
         head_s = {ENT_W{1'b0}};
      end
      rd_en_s   = (state_r == ST_ISSUE) && (occupancy_s < 3'd2);
      last_rd_s = (pix_cnt_r == PIX_LAST) && (sv_cnt_r == SV_LAST);
   end

   // Frame FSM, read address counters, issue tags and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         pix_cnt_r  <= {PIX_W{1'b0}};
         sv_cnt_r   <= {SV_W{1'b0}};
         lin_cnt_r  <= {ADDR_W{1'b0}};
         inflight_r <= 1'b0;
         tag_r      <= {(SV_W+2){1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
         done_r     <= 1'b0;
         if (rd_en_s) begin
            tag_r <= {sv_cnt_r, pix_cnt_r == {PIX_W{1'b0}}, pix_cnt_r == PIX_LAST};
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_ISSUE;
                  busy_r  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // Counters freeze on the final read so they never run past the frame
               if (rd_en_s) begin
                  if (last_rd_s) begin
                     state_r <= ST_DRAIN;
                  end else if (pix_cnt_r == PIX_LAST) begin
                     pix_cnt_r <= {PIX_W{1'b0}};
                     sv_cnt_r  <= sv_cnt_r + SV_W'(1'b1);
                     lin_cnt_r <= lin_cnt_r + ADDR_W'(1'b1);
                  end else begin
                     pix_cnt_r <= pix_cnt_r + PIX_W'(1'b1);
                     lin_cnt_r <= lin_cnt_r + ADDR_W'(1'b1);
                  end
               end
            end
            ST_DRAIN: begin
               if (xfer_s && (occupancy_s == 3'd1)) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r   <= ST_IDLE;
               pix_cnt_r <= {PIX_W{1'b0}};
               sv_cnt_r  <= {SV_W{1'b0}};
               lin_cnt_r <= {ADDR_W{1'b0}};
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign test_addr = pix_cnt_r;
   assign sv_addr   = lin_cnt_r;
   assign rd_en     = rd_en_s;
   assign x_test    = head_s[ENT_W-1:XT_LO];
   assign x_sv      = head_s[XT_LO-1:XS_LO];
   assign sv_idx    = head_s[SV_W+1:2];
   assign px_first  = head_s[1];
   assign px_last   = head_s[0];
   assign stall_MEM = ~xfer_s;
   assign Bi        = BI_INIT;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_hwf_operand_streamer.sv
// Directed bench for hwf_operand_streamer: 4 pixels x 3 SVs, table of expected pairs.
module tb_hwf_operand_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        kernel_rdy;
   logic [1:0]  test_addr;
   logic [7:0]  test_rdata;
   logic [3:0]  sv_addr;
   logic [7:0]  sv_rdata;
   logic        rd_en;
   logic [7:0]  x_test;
   logic [7:0]  x_sv;
   logic [15:0] Bi;
   logic [1:0]  sv_idx;
   logic        px_first;
   logic        px_last;
   logic        stall_MEM;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] xt;
      logic [7:0] xs;
      logic [1:0] idx;
      logic       f;
      logic       l;
   } pair_t;

   pair_t exp_tab [12];
   pair_t got [$];

   hwf_operand_streamer #(
      .XLEN_PIXEL    (8),
      .NUM_OF_PIXELS (4),
      .NUM_OF_SV     (3),
      .BI_INIT       (16'h0100)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .kernel_rdy (kernel_rdy),
      .test_addr  (test_addr),
      .test_rdata (test_rdata),
      .sv_addr    (sv_addr),
      .sv_rdata   (sv_rdata),
      .rd_en      (rd_en),
      .x_test     (x_test),
      .x_sv       (x_sv),
      .Bi         (Bi),
      .sv_idx     (sv_idx),
      .px_first   (px_first),
      .px_last    (px_last),
      .stall_MEM  (stall_MEM),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Synchronous ROMs: sv_mem[a] = a, test_mem[p] = 8'h10 + p
   always @(posedge clk) begin
      if (rd_en) begin
         test_rdata <= 8'h10 + {6'd0, test_addr};
         sv_rdata   <= {4'd0, sv_addr};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // mode 1: rdy high; 2: rdy low cycles 4-8; 3: repeated start; 4: reset at cycle 7; 5: rdy toggling
   task automatic run_frame(input int mode, input int maxc);
      int rd_cnt;
      int dones;
      int done_cyc;
      int exp_cyc;
      int n_exp;
      got.delete();
      rd_cnt   = 0;
      dones    = 0;
      done_cyc = (mode == 2) ? 19 : (mode == 5) ? 25 : (mode == 4) ? -1 : 14;
      for (int k = 0; k < maxc; k++) begin
         @(posedge clk);
         #1;
         start      = (k == 0) || (mode == 3 && (k == 5 || k == 9 || k == 14));
         kernel_rdy = (mode == 2) ? !(k >= 4 && k <= 8) : (mode == 5) ? (k % 2 == 0) : 1'b1;
         if (mode == 4 && k == 7) rst_n = 1'b0;
         if (mode == 4 && k == 8) rst_n = 1'b1;
         @(negedge clk);
         if (!stall_MEM) got.push_back('{k, x_test, x_sv, sv_idx, px_first, px_last});
         chk("bi_const", Bi, 16'h0100);
         if (rd_en) begin
            chk("sv_addr", sv_addr, rd_cnt);
            chk("test_addr", test_addr, rd_cnt % 4);
            rd_cnt++;
         end
         if (mode == 1) chk("rd_en_full_rate", rd_en, (k >= 1 && k <= 12));
         if (mode == 2) chk("rd_en_throttle", rd_en, (k >= 1 && k <= 4) || (k >= 10 && k <= 17));
         if (mode == 2 && k >= 4 && k <= 8) begin
            chk("frozen_stall", stall_MEM, 1'b1);
            chk("frozen_x_test", x_test, 8'h12);
            chk("frozen_x_sv", x_sv, 8'h02);
         end
         if (mode == 4 && k >= 7) begin
            chk("rst_stall", stall_MEM, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rd_en", rd_en, 1'b0);
            chk("rst_x_test", x_test, 8'h00);
         end
         if (mode != 4) begin
            chk("busy", busy, (k >= 1 && k < done_cyc));
            chk("done", done, (k == done_cyc));
         end
         dones += int'(done);
      end
      n_exp = (mode == 4) ? 5 : 12;
      chk("pair_count", got.size(), n_exp);
      for (int p = 0; p < got.size() && p < 12; p++) begin
         exp_cyc = (mode == 5) ? 2 + 2*p : (mode == 2 && p >= 2) ? exp_tab[p].cyc + 5 : exp_tab[p].cyc;
         chk("pair_cycle", got[p].cyc, exp_cyc);
         chk("pair_x_test", got[p].xt, exp_tab[p].xt);
         chk("pair_x_sv", got[p].xs, exp_tab[p].xs);
         chk("pair_sv_idx", got[p].idx, exp_tab[p].idx);
         chk("pair_px_first", got[p].f, exp_tab[p].f);
         chk("pair_px_last", got[p].l, exp_tab[p].l);
      end
      if (mode != 4) begin
         chk("done_count", dones, 1);
         chk("read_count", rd_cnt, 12);
      end
   endtask

   initial begin
      // {cycle with rdy high, x_test, x_sv, sv_idx, px_first, px_last}
      exp_tab = '{
         '{2,  8'h10, 8'h00, 2'd0, 1'b1, 1'b0},
         '{3,  8'h11, 8'h01, 2'd0, 1'b0, 1'b0},
         '{4,  8'h12, 8'h02, 2'd0, 1'b0, 1'b0},
         '{5,  8'h13, 8'h03, 2'd0, 1'b0, 1'b1},
         '{6,  8'h10, 8'h04, 2'd1, 1'b1, 1'b0},
         '{7,  8'h11, 8'h05, 2'd1, 1'b0, 1'b0},
         '{8,  8'h12, 8'h06, 2'd1, 1'b0, 1'b0},
         '{9,  8'h13, 8'h07, 2'd1, 1'b0, 1'b1},
         '{10, 8'h10, 8'h08, 2'd2, 1'b1, 1'b0},
         '{11, 8'h11, 8'h09, 2'd2, 1'b0, 1'b0},
         '{12, 8'h12, 8'h0A, 2'd2, 1'b0, 1'b0},
         '{13, 8'h13, 8'h0B, 2'd2, 1'b0, 1'b1}
      };
      rst_n      = 1'b0;
      start      = 1'b0;
      kernel_rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", stall_MEM, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_rd_en", rd_en, 1'b0);
      chk("reset_px_first", px_first, 1'b0);
      chk("reset_px_last", px_last, 1'b0);
      chk("reset_test_addr", test_addr, 2'd0);
      chk("reset_sv_addr", sv_addr, 4'd0);
      chk("reset_x_test", x_test, 8'h00);
      chk("reset_x_sv", x_sv, 8'h00);
      chk("reset_sv_idx", sv_idx, 2'd0);
      chk("reset_bi", Bi, 16'h0100);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_frame(1, 17);
      run_frame(2, 22);
      run_frame(3, 17);
      run_frame(4, 9);
      run_frame(1, 17);
      run_frame(5, 28);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
